// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: round-robin arbiter sharing one cache bus among NUM_INPUTS
// requesters. A grant is held for a whole burst and released after the final
// beat handshake or when the granted requester drops valid. There is always one
// idle bubble cycle between transactions.
// Optional: define CBUS_ARB_STATS_EN to add saturating per-requester
// grant_cnt / wait_cnt counters.

package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  len;    // burst length minus one
    logic [31:0] wdata;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter  int NUM_INPUTS = 2,
  localparam int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  cbus_req_t  [NUM_INPUTS-1:0]      ireqs,
  output cbus_resp_t [NUM_INPUTS-1:0]      iresps,
  output cbus_req_t                        oreq,
  input  cbus_resp_t                       oresp,
  output logic                             grant_valid,
  output logic [IDX_W-1:0]                 grant_idx
`ifdef CBUS_ARB_STATS_EN
  ,
  output logic [NUM_INPUTS-1:0][31:0]      grant_cnt,
  output logic [NUM_INPUTS-1:0][31:0]      wait_cnt
`endif
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;

  logic [NUM_INPUTS-1:0] req_vld;
  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic                  done;

  // Gather the valid bits of all requesters
  always_comb begin
    req_vld = '0;
    for (int i = 0; i < NUM_INPUTS; i++) req_vld[i] = ireqs[i].valid;
  end

  // Round-robin pick: first valid requester scanning from last_idx+1, wrapping
  always_comb begin
    int cand;
    cand       = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      cand = int'(last_idx_q) + k;
      if (cand >= NUM_INPUTS) cand = cand - NUM_INPUTS;
      if (!pick_found && req_vld[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Transaction ends on the final beat handshake or when the owner withdraws
  assign done = (oresp.ready && oresp.last) || !req_vld[grant_idx_q];

  // Next-state logic for the grant FSM
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    last_idx_d  = last_idx_q;
    case (state_q)
      IDLE: if (pick_found) begin
        state_d     = BUSY;
        grant_idx_d = pick_idx;
      end
      BUSY: if (done) begin
        state_d    = IDLE;
        last_idx_d = grant_idx_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant FSM registers; reset makes index 0 the first candidate
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      last_idx_q  <= IDX_W'(NUM_INPUTS - 1);
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      last_idx_q  <= last_idx_d;
    end
  end

  // Steer the owner's request out and the memory response back to the owner only
  always_comb begin
    oreq   = '0;
    iresps = '0;
    if (state_q == BUSY) begin
      oreq                = ireqs[grant_idx_q];
      iresps[grant_idx_q] = oresp;
    end
  end

  assign grant_valid = (state_q == BUSY);
  assign grant_idx   = grant_idx_q;

`ifdef CBUS_ARB_STATS_EN
  logic [NUM_INPUTS-1:0][31:0] grant_cnt_q, grant_cnt_d;
  logic [NUM_INPUTS-1:0][31:0] wait_cnt_q, wait_cnt_d;

  // Saturating counters: grants taken and cycles spent waiting unserved
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (state_q == IDLE && pick_found && int'(pick_idx) == i &&
          grant_cnt_q[i] != 32'hFFFF_FFFF)
        grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
      if (req_vld[i] && !(state_q == BUSY && int'(grant_idx_q) == i) &&
          wait_cnt_q[i] != 32'hFFFF_FFFF)
        wait_cnt_d[i] = wait_cnt_q[i] + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign wait_cnt  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed self-checking bench for cbus_rr_arbiter: a 2-input instance for
// most scenarios and a 3-input instance for wrap-around ordering.
module tb_cbus_rr_arbiter;
  import cbus_pkg::*;

  logic clk;
  logic reset;

  cbus_req_t  [1:0] ireqs;
  cbus_resp_t [1:0] iresps;
  cbus_req_t        oreq;
  cbus_resp_t       oresp;
  logic             grant_valid;
  logic [0:0]       grant_idx;

  cbus_req_t  [2:0] ireqs3;
  cbus_resp_t [2:0] iresps3;
  cbus_req_t        oreq3;
  cbus_resp_t       oresp3;
  logic             grant_valid3;
  logic [1:0]       grant_idx3;

`ifdef CBUS_ARB_STATS_EN
  logic [1:0][31:0] grant_cnt, wait_cnt;
  logic [2:0][31:0] grant_cnt3, wait_cnt3;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cbus_rr_arbiter #(.NUM_INPUTS(2)) dut (
    .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(iresps),
    .oreq(oreq), .oresp(oresp), .grant_valid(grant_valid), .grant_idx(grant_idx)
`ifdef CBUS_ARB_STATS_EN
    , .grant_cnt(grant_cnt), .wait_cnt(wait_cnt)
`endif
  );

  cbus_rr_arbiter #(.NUM_INPUTS(3)) dut3 (
    .clk(clk), .reset(reset), .ireqs(ireqs3), .iresps(iresps3),
    .oreq(oreq3), .oresp(oresp3), .grant_valid(grant_valid3), .grant_idx(grant_idx3)
`ifdef CBUS_ARB_STATS_EN
    , .grant_cnt(grant_cnt3), .wait_cnt(wait_cnt3)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic cbus_req_t mk_req(input logic v, input logic [31:0] a,
                                       input logic [3:0] l, input logic [31:0] d);
    cbus_req_t r;
    r.valid = v; r.we = 1'b1; r.addr = a; r.len = l; r.wdata = d;
    return r;
  endfunction

  function automatic cbus_resp_t mk_resp(input logic r, input logic l, input logic [31:0] d);
    cbus_resp_t s;
    s.ready = r; s.last = l; s.data = d;
    return s;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic reset_dut();
    reset  = 1'b1;
    ireqs  = '0; oresp  = '0;
    ireqs3 = '0; oresp3 = '0;
    step(); step();
    reset = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ireqs[0] = mk_req(1'b1, 32'h10, 4'd0, 32'h1);
    ireqs[1] = mk_req(1'b1, 32'h20, 4'd0, 32'h2);
    oresp    = mk_resp(1'b1, 1'b1, 32'hFFFF_0000);
    step();
    n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_grant_valid: got %b want 0", grant_valid); end
    n_checks++; if (grant_idx !== 1'b0) begin n_fail++; $display("FAIL reset_grant_idx: got %0d want 0", grant_idx); end
    n_checks++; if (oreq !== '0) begin n_fail++; $display("FAIL reset_oreq: got %h want 0", oreq); end
    n_checks++; if (iresps !== '0) begin n_fail++; $display("FAIL reset_iresps: got %h want 0", iresps); end
    n_checks++; if (grant_valid3 !== 1'b0 || oreq3 !== '0) begin n_fail++; $display("FAIL reset_dut3: got gv=%b oreq=%h want 0", grant_valid3, oreq3); end
    reset_dut();
  endtask

  // One 4-beat burst on requester 0
  task automatic test_single();
    cbus_req_t  r0;
    cbus_resp_t e;
    reset_dut();
    r0 = mk_req(1'b1, 32'h100, 4'd3, 32'hA5A5_0000);
    ireqs[0] = r0;
    settle();
    n_checks++; if (grant_valid !== 1'b0 || oreq.valid !== 1'b0) begin n_fail++; $display("FAIL single_latency: got gv=%b ov=%b want 0 0", grant_valid, oreq.valid); end
    step();
    n_checks++; if (grant_valid !== 1'b1 || grant_idx !== 1'b0) begin n_fail++; $display("FAIL single_grant: got gv=%b idx=%0d want 1 0", grant_valid, grant_idx); end
    n_checks++; if (oreq !== r0) begin n_fail++; $display("FAIL single_oreq: got %h want %h", oreq, r0); end
    for (int b = 0; b < 4; b++) begin
      e = mk_resp(1'b1, (b == 3), 32'hD000_0000 + 32'(b));
      oresp = e;
      settle();
      n_checks++; if (iresps[0] !== e) begin n_fail++; $display("FAIL single_beat%0d: got %h want %h", b, iresps[0], e); end
      n_checks++; if (iresps[1] !== '0) begin n_fail++; $display("FAIL single_other%0d: got %h want 0", b, iresps[1]); end
      n_checks++; if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL single_hold%0d: got %b want 1", b, grant_valid); end
      step();
    end
    ireqs[0].valid = 1'b0;
    oresp = '0;
    settle();
    n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b want 0", grant_valid); end
    oresp = mk_resp(1'b1, 1'b1, 32'hBAD0_BAD0);
    settle();
    n_checks++; if (iresps !== '0 || oreq !== '0) begin n_fail++; $display("FAIL idle_resp_ignored: got iresps=%h oreq=%h want 0", iresps, oreq); end
    oresp = '0;
    step();
  endtask

  // Both requesters always valid: grants alternate with one bubble between
  task automatic test_alternate();
    cbus_req_t  r[2];
    cbus_resp_t e;
    logic [0:0] x;
    reset_dut();
    r[0] = mk_req(1'b1, 32'h200, 4'd0, 32'h0000_0200);
    r[1] = mk_req(1'b1, 32'h300, 4'd0, 32'h0000_0300);
    ireqs[0] = r[0];
    ireqs[1] = r[1];
    settle();
    step();
    for (int t = 0; t < 4; t++) begin
      x = 1'(t % 2);
      n_checks++; if (grant_valid !== 1'b1 || grant_idx !== x) begin n_fail++; $display("FAIL alt_grant%0d: got gv=%b idx=%0d want 1 %0d", t, grant_valid, grant_idx, x); end
      n_checks++; if (oreq !== r[x]) begin n_fail++; $display("FAIL alt_oreq%0d: got %h want %h", t, oreq, r[x]); end
      e = mk_resp(1'b1, 1'b1, 32'hC000_0000 + 32'(t));
      oresp = e;
      settle();
      n_checks++; if (iresps[x] !== e || iresps[~x] !== '0) begin n_fail++; $display("FAIL alt_resp%0d: got %h want %h/0", t, iresps, e); end
      step();
      oresp = '0;
      settle();
      n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL alt_bubble%0d: got %b want 0", t, grant_valid); end
      step();
    end
    // Fifth grant goes to 0; the owner withdrawing ends the transaction
    n_checks++; if (grant_valid !== 1'b1 || grant_idx !== 1'b0) begin n_fail++; $display("FAIL alt_grant4: got gv=%b idx=%0d want 1 0", grant_valid, grant_idx); end
    ireqs = '0;
    settle();
    n_checks++; if (oreq.valid !== 1'b0) begin n_fail++; $display("FAIL withdraw_oreq: got %b want 0", oreq.valid); end
    step();
    n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL withdraw_exit: got %b want 0", grant_valid); end
  endtask

  // Requester 1 rises mid-burst; grant stays on 0 until the last beat
  task automatic test_hold();
    reset_dut();
    ireqs[0] = mk_req(1'b1, 32'h400, 4'd2, 32'h4);
    settle();
    step();
    for (int b = 0; b < 3; b++) begin
      oresp = mk_resp(1'b1, (b == 2), 32'hE000_0000 + 32'(b));
      if (b == 0) ireqs[1] = mk_req(1'b1, 32'h500, 4'd0, 32'h5);
      settle();
      n_checks++; if (grant_idx !== 1'b0 || grant_valid !== 1'b1) begin n_fail++; $display("FAIL hold_idx%0d: got gv=%b idx=%0d want 1 0", b, grant_valid, grant_idx); end
      n_checks++; if (iresps[1] !== '0) begin n_fail++; $display("FAIL hold_waiter%0d: got %h want 0", b, iresps[1]); end
      step();
    end
    oresp = '0;
    settle();
    n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL hold_bubble: got %b want 0", grant_valid); end
    step();
    n_checks++; if (grant_valid !== 1'b1 || grant_idx !== 1'b1) begin n_fail++; $display("FAIL hold_next: got gv=%b idx=%0d want 1 1", grant_valid, grant_idx); end
    ireqs = '0;
    step();
  endtask

  // Reset in the 2nd beat drops the burst; afterwards index 0 wins again
  task automatic test_reset_mid();
    reset_dut();
    ireqs[0] = mk_req(1'b1, 32'h600, 4'd3, 32'h6);
    ireqs[1] = mk_req(1'b1, 32'h700, 4'd3, 32'h7);
    settle();
    step();
    oresp = mk_resp(1'b1, 1'b0, 32'h1111_1111);
    settle();
    step();
    oresp = mk_resp(1'b1, 1'b0, 32'h2222_2222);
    reset = 1'b1;
    settle();
    n_checks++; if (oreq.valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_oreq: got %b want 0", oreq.valid); end
    n_checks++; if (iresps !== '0) begin n_fail++; $display("FAIL rstmid_iresps: got %h want 0", iresps); end
    n_checks++; if (grant_valid !== 1'b0 || grant_idx !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: got gv=%b idx=%0d want 0 0", grant_valid, grant_idx); end
    step();
    reset = 1'b0;
    oresp = '0;
    settle();
    step();
    n_checks++; if (grant_valid !== 1'b1 || grant_idx !== 1'b0) begin n_fail++; $display("FAIL rstmid_regrant: got gv=%b idx=%0d want 1 0", grant_valid, grant_idx); end
    ireqs = '0;
    step();
  endtask

  // Three inputs: after serving 1, valids {0,2} grant 2 then 0
  task automatic test_wrap();
    reset_dut();
    ireqs3[1] = mk_req(1'b1, 32'h800, 4'd0, 32'h8);
    settle();
    step();
    n_checks++; if (grant_valid3 !== 1'b1 || grant_idx3 !== 2'd1) begin n_fail++; $display("FAIL wrap_first: got gv=%b idx=%0d want 1 1", grant_valid3, grant_idx3); end
    oresp3 = mk_resp(1'b1, 1'b1, 32'h8888_0000);
    settle();
    step();
    oresp3 = '0;
    ireqs3[1] = '0;
    ireqs3[0] = mk_req(1'b1, 32'h900, 4'd0, 32'h9);
    ireqs3[2] = mk_req(1'b1, 32'hA00, 4'd0, 32'hA);
    settle();
    n_checks++; if (grant_valid3 !== 1'b0) begin n_fail++; $display("FAIL wrap_bubble: got %b want 0", grant_valid3); end
    step();
    n_checks++; if (grant_valid3 !== 1'b1 || grant_idx3 !== 2'd2) begin n_fail++; $display("FAIL wrap_to2: got gv=%b idx=%0d want 1 2", grant_valid3, grant_idx3); end
    n_checks++; if (oreq3.addr !== 32'hA00) begin n_fail++; $display("FAIL wrap_oreq: got %h want a00", oreq3.addr); end
    oresp3 = mk_resp(1'b1, 1'b1, 32'hAAAA_0000);
    settle();
    step();
    oresp3 = '0;
    settle();
    step();
    n_checks++; if (grant_valid3 !== 1'b1 || grant_idx3 !== 2'd0) begin n_fail++; $display("FAIL wrap_to0: got gv=%b idx=%0d want 1 0", grant_valid3, grant_idx3); end
    ireqs3 = '0;
    step();
  endtask

`ifdef CBUS_ARB_STATS_EN
  // Requester 1 waits 5 cycles behind a 3-beat burst on requester 0
  task automatic test_stats();
    reset_dut();
    n_checks++; if (grant_cnt !== '0 || wait_cnt !== '0) begin n_fail++; $display("FAIL stats_reset: got g=%h w=%h want 0", grant_cnt, wait_cnt); end
    ireqs[0] = mk_req(1'b1, 32'hB00, 4'd2, 32'hB);
    ireqs[1] = mk_req(1'b1, 32'hC00, 4'd0, 32'hC);
    settle();
    step();
    for (int b = 0; b < 3; b++) begin
      oresp = mk_resp(1'b1, (b == 2), 32'(b));
      settle();
      step();
    end
    oresp = '0;
    ireqs[0].valid = 1'b0;
    settle();
    step();
    n_checks++; if (grant_valid !== 1'b1 || grant_idx !== 1'b1) begin n_fail++; $display("FAIL stats_grant1: got gv=%b idx=%0d want 1 1", grant_valid, grant_idx); end
    n_checks++; if (wait_cnt[1] !== 32'd5) begin n_fail++; $display("FAIL stats_wait1: got %0d want 5", wait_cnt[1]); end
    n_checks++; if (wait_cnt[0] !== 32'd1) begin n_fail++; $display("FAIL stats_wait0: got %0d want 1", wait_cnt[0]); end
    n_checks++; if (grant_cnt[0] !== 32'd1 || grant_cnt[1] !== 32'd1) begin n_fail++; $display("FAIL stats_grants: got %0d %0d want 1 1", grant_cnt[0], grant_cnt[1]); end
    ireqs = '0;
    step();
  endtask
`endif

  initial begin
    reset = 1'b1;
    ireqs = '0; oresp = '0; ireqs3 = '0; oresp3 = '0;
    test_reset();
    test_single();
    test_alternate();
    test_hold();
    test_reset_mid();
    test_wrap();
`ifdef CBUS_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
